// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: op codes, legality check
// and the response entry layout carried through the response FIFO.
package alu_pkg;

  localparam int ALU_W = 64;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;

  typedef struct packed {
    logic             id;
    logic [ALU_W-1:0] result;
    logic             zero;
    logic             illegal;
  } resp_entry_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB,
      ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational integer ALU; unknown op codes produce zero.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] result
);

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] shamt;
  assign shamt = b[SH_W-1:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_XOR: result = a ^ b;
      ALU_SLL: result = a << shamt;
      ALU_SRL: result = a >> shamt;
      ALU_SRA: result = $unsigned($signed(a) >>> shamt);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/resp_fifo.sv
// Small synchronous FIFO with combinational head read; a pop frees a slot
// for a push in the same cycle even when full.
module resp_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg, count_next;
  logic             do_push, do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = count_reg;
  assign dout    = mem[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end for a shared ALU; results are queued
// with the issuing requester id and returned in acceptance order.
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W     = ALU_W,
  parameter int RESP_DEPTH = 2,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [3:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [3:0]        req1_op,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_zero,
  output logic              resp_illegal,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
);

  localparam int EW = $bits(resp_entry_t);
  localparam int CW = $clog2(RESP_DEPTH + 1);

  logic              rr_ptr_reg;
  logic [1:0]        valid, grant, accept;
  logic              space, push, empty, full;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] sel_a, sel_b, alu_result;
  logic [3:0]        sel_op;
  resp_entry_t       push_entry, head_entry;

  assign valid    = {req1_valid, req0_valid};
  // rr_ptr only breaks ties; a lone valid requester always wins.
  assign grant[0] = valid[0] && (!valid[1] || !rr_ptr_reg);
  assign grant[1] = valid[1] && (!valid[0] ||  rr_ptr_reg);

  assign space      = (count < CW'(RESP_DEPTH)) || (resp_valid && resp_ready);
  assign req0_ready = grant[0] && space && rst_n;
  assign req1_ready = grant[1] && space && rst_n;
  assign accept     = {req1_valid && req1_ready, req0_valid && req0_ready};
  assign push       = |accept;

  assign sel_a  = grant[1] ? req1_a  : req0_a;
  assign sel_b  = grant[1] ? req1_b  : req0_b;
  assign sel_op = grant[1] ? req1_op : req0_op;

  alu #(.DATA_W(DATA_W)) u_alu (
    .a      (sel_a),
    .b      (sel_b),
    .op     (sel_op),
    .result (alu_result)
  );

  always_comb begin
    push_entry         = '0;
    push_entry.id      = grant[1];
    push_entry.illegal = !is_legal_op(sel_op);
    push_entry.result  = push_entry.illegal ? '0 : ALU_W'(alu_result);
    push_entry.zero    = (push_entry.result == '0);
  end

  resp_fifo #(.WIDTH(EW), .DEPTH(RESP_DEPTH)) u_resp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_entry),
    .pop   (resp_valid && resp_ready),
    .dout  (head_entry),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  assign resp_valid   = !empty;
  assign resp_id      = resp_valid && head_entry.id;
  assign resp_result  = resp_valid ? DATA_W'(head_entry.result) : '0;
  assign resp_zero    = resp_valid && head_entry.zero;
  assign resp_illegal = resp_valid && head_entry.illegal;

  always_ff @(posedge clk) begin
    if (!rst_n)         rr_ptr_reg <= 1'b0;
    else if (accept[0]) rr_ptr_reg <= 1'b1;
    else if (accept[1]) rr_ptr_reg <= 1'b0;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (!rst_n)                           cnt_reg <= '0;
      else if (accept[gi] && cnt_reg != '1) cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign grant_cnt0 = g_cnt[0].cnt_reg;
  assign grant_cnt1 = g_cnt[1].cnt_reg;

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
Shares one 64-bit combinational ALU instance between two requesters using round-robin arbitration with valid/ready handshakes on both request ports. Each accepted operation is evaluated by the ALU in the accept cycle. The result is captured into a small response FIFO tagged with the requester ID and returned over a single shared response channel. The block sits between the issue stages of two execution clients and the integer datapath.

Parameters:
DATA_W, 64, operand/result width; ALU shift amount uses the low 6 bits of B
RESP_DEPTH, 2, response FIFO entries; power of two, minimum 2
CNT_W, 32, width of per-requester grant counters

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle when valid&ready
req0_a  in  DATA_W  operand A
req0_b  in  DATA_W  operand B
req0_op  in  4  ALU control code
req1_valid / req1_ready / req1_a / req1_b / req1_op  as above, requester 1
resp_valid  out  1  response FIFO head valid
resp_ready  in  1  consumer takes head when valid&ready
resp_id  out  1  requester that issued the head operation
resp_result  out  DATA_W  ALU result
resp_zero  out  1  result == 0
resp_illegal  out  1  op was not a legal code
grant_cnt0  out  CNT_W  saturating count of requester-0 acceptances
grant_cnt1  out  CNT_W  same for requester 1

Behaviour:
- Legal op codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0100 XOR, 1000 SLL, 1001 SRL, 1010 SRA. Shifts use B[5:0]. Add and sub wrap modulo 2^DATA_W. SRA is arithmetic on signed A.
- Any other op: result 0, zero 1, illegal 1. The request is still accepted and a response is still returned.
- space = (count < RESP_DEPTH) OR (resp_valid AND resp_ready). Simultaneous pop and push when full is allowed.
- Arbitration is combinational on the valid inputs:
  - If only one requester is valid, it is granted.
  - If both are valid, rr_ptr selects the granted requester.
- reqN_ready = grantN AND space. At most one ready is high per cycle. A requester that is not valid never gets ready.
- On acceptance:
  - The mux selects the operands, the ALU evaluates them, and {id, result, zero, illegal} is pushed in the same cycle.
  - rr_ptr <= the other requester.
  - The granted counter increments, saturating at all-ones.
- rr_ptr is unchanged when nothing is accepted. Priority never moves on a stall.
- Latency: an operation accepted in cycle T is visible at resp_* in cycle T+1 if the FIFO was empty or is draining to that entry. Throughput is 1 op/cycle with a continuously ready consumer.
- Responses are returned in acceptance order. resp_* shows the FIFO head and holds stable while resp_valid is high and resp_ready is low.
- When empty: resp_valid 0 and resp_id/result/zero/illegal driven 0.
- FIFO read/write pointers wrap modulo RESP_DEPTH. count ranges 0..RESP_DEPTH.
- Reset (rst_n low at clock edge):
  - count, pointers, rr_ptr and grant counters go to 0; rr_ptr 0 means requester 0 is preferred.
  - All outputs read 0 the cycle after.
  - Reset mid-operation discards all buffered responses; nothing in flight survives.
  - While rst_n is low, req0_ready and req1_ready are 0.
- Requester input stability while valid and not ready is the requester's obligation. The block does not latch operands before acceptance.

Decomposition:
- Shared package alu_pkg holds:
  - op-code localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA)
  - an is_legal_op function
  - the resp_entry_t struct {id, result, zero, illegal}
- One sub-module: resp_fifo, a synchronous FIFO parameterised on width and depth, with push/pop/count and support for simultaneous push and pop when full.
- The existing ALU module is instantiated unchanged; is_legal_op generates the illegal flag.

Test Plan:
- Reset, then req0 valid with a=5, b=3, op=0010 and resp_ready=1 -> req0_ready=1 in cycle 0; cycle 1 shows resp_valid=1, id=0, result=8, zero=0, illegal=0; grant_cnt0=1.
- Both requesters valid for 4 cycles with resp_ready=1 (req0 SUB 7-7, req1 SRA a=0x8000_0000_0000_0000 b=4) -> grants alternate 0,1,0,1. Responses: id0 result 0 with zero=1; id1 result 0xF800_0000_0000_0000.
- resp_ready=0 and both valid -> exactly RESP_DEPTH=2 acceptances, then both ready stay 0. rr_ptr is frozen, and after resp_ready=1 grants resume from the held pointer.
- FIFO full and resp_ready=1 in the same cycle as a new req1 -> pop and push both occur, count stays 2, and no response is lost or reordered.
- req1 op=1111 with a=9, b=9 -> accepted; response id=1, result 0, zero 1, illegal 1.
- rst_n low for one cycle with 2 entries buffered and requests pending -> next cycle resp_valid=0, counters 0, both ready 0 during reset. The first post-reset grant goes to requester 0 when both are valid.
